// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit: FSM states,
// RV32I opcodes, ALU operation codes and ALU status flag positions.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  localparam int STAT_Z = 3;
  localparam int STAT_N = 2;
  localparam int STAT_C = 1;
  localparam int STAT_V = 0;

  // Branch outcome from the flags of rs1 - rs2; funct3 values are pre-filtered to legal ones.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic [3:0] status);
    logic lt;
    lt = status[STAT_N] ^ status[STAT_V];
    case (funct3)
      3'b000:  return status[STAT_Z];
      3'b001:  return !status[STAT_Z];
      3'b100:  return lt;
      3'b101:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of opcode/funct3/funct7[5] into an ALU operation
// and a legality flag for the supported RV32I subset.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] aluop,
  output logic       legal
);

  always_comb begin
    aluop = ALU_ADD;
    legal = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        legal = 1'b1;
        case (funct3)
          3'b000:  aluop = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  aluop = ALU_SLL;
          3'b010:  aluop = ALU_SLT;
          3'b100:  aluop = ALU_XOR;
          3'b101:  aluop = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  aluop = ALU_OR;
          3'b111:  aluop = ALU_AND;
          default: legal = 1'b0;
        endcase
        // Register forms only allow funct7[5] on the SUB and SRA encodings.
        if (opcode == OP_R && funct7_5 && funct3 != 3'b000 && funct3 != 3'b101)
          legal = 1'b0;
      end
      OP_LOAD, OP_STORE: begin
        aluop = ALU_ADD;
        legal = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        aluop = ALU_SUB;
        legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FSM controller for the RV32I-subset datapath: latches the
// instruction, sequences FETCH/DECODE/EXEC/MEM/WB and counts retirements.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [31:0]          instr,
  input  logic [3:0]           status,
  output logic                 pc_we,
  output logic                 pcsrc,
  output logic                 wb,
  output logic                 alusrc,
  output logic [3:0]           aluop,
  output logic                 immgen_ctrl,
  output logic                 mrw,
  output logic                 regrw,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  state_t      state, state_next;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [3:0]  dec_aluop;
  logic        dec_legal;
  logic        unused_bits;

  assign opcode      = ir[6:0];
  assign funct3      = ir[14:12];
  assign unused_bits = ^{ir[31], ir[29:15], ir[11:7], status[STAT_C]};

  alu_decoder u_alu_decoder (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (ir[30]),
    .aluop    (dec_aluop),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && en)
        ir <= instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      instret <= '0;
    else if (pc_we)
      instret <= instret + INSTRET_W'(1);
  end

  // Every output is a pure function of state and IR; only branch EXEC looks at status.
  always_comb begin
    state_next  = state;
    pc_we       = 1'b0;
    pcsrc       = 1'b0;
    wb          = 1'b0;
    alusrc      = 1'b0;
    aluop       = ALU_ADD;
    immgen_ctrl = 1'b0;
    mrw         = 1'b0;
    regrw       = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH:  if (en) state_next = S_DECODE;
      S_DECODE: state_next = dec_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        aluop = dec_aluop;
        case (opcode)
          OP_BRANCH: begin
            immgen_ctrl = 1'b1;
            pc_we       = 1'b1;
            pcsrc       = branch_taken(funct3, status);
            state_next  = S_FETCH;
          end
          OP_LOAD, OP_STORE: begin
            wb          = 1'b1;
            immgen_ctrl = (opcode == OP_STORE);
            state_next  = S_MEM;
          end
          default: begin
            wb         = (opcode == OP_I);
            state_next = S_WB;
          end
        endcase
      end
      S_MEM: begin
        if (opcode == OP_STORE) begin
          mrw        = 1'b1;
          pc_we      = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_WB: begin
        regrw      = 1'b1;
        pc_we      = 1'b1;
        alusrc     = (opcode == OP_LOAD);
        state_next = S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a mnemonic-level model queues the
// expected outputs of every cycle, and a negedge monitor compares them.
module tb_multicycle_ctrl;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [31:0]   instr = '0;
  logic [3:0]    status = '0;
  logic          pc_we, pcsrc, wb, alusrc, immgen_ctrl, mrw, regrw, halted;
  logic [3:0]    aluop;
  logic [IW-1:0] instret;

  multicycle_ctrl #(.INSTRET_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .instr       (instr),
    .status      (status),
    .pc_we       (pc_we),
    .pcsrc       (pcsrc),
    .wb          (wb),
    .alusrc      (alusrc),
    .aluop       (aluop),
    .immgen_ctrl (immgen_ctrl),
    .mrw         (mrw),
    .regrw       (regrw),
    .halted      (halted),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          pc_we;
    logic          pcsrc;
    logic          wb;
    logic          alusrc;
    logic [3:0]    aluop;
    logic          immgen_ctrl;
    logic          mrw;
    logic          regrw;
    logic          halted;
    logic [IW-1:0] instret;
  } out_t;

  typedef struct {
    out_t  v;
    string tag;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    passes = 0;
  int    model_cnt = 0;

  string alu_names[8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
  string br_names[8]  = '{"BEQ", "BNE", "BAD", "BAD", "BLT", "BGE", "BAD", "BAD"};
  string op_names[9]  = '{"ADD", "SUB", "AND", "OR", "XOR", "SLL", "SRL", "SRA", "SLT"};

  function automatic out_t mk(bit pw, bit ps, bit b, bit as, logic [3:0] op,
                              bit ig, bit m, bit r, bit h);
    out_t o;
    o.pc_we = pw; o.pcsrc = ps; o.wb = b; o.alusrc = as; o.aluop = op;
    o.immgen_ctrl = ig; o.mrw = m; o.regrw = r; o.halted = h;
    o.instret = model_cnt[IW-1:0];
    return o;
  endfunction

  function automatic out_t mk0();
    return mk(0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
  endfunction

  // 0 R-ALU, 1 I-ALU, 2 load, 3 store, 4 branch, 5 unknown
  function automatic int kind(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      default:    return 5;
    endcase
  endfunction

  function automatic string mnemonic(input logic [31:0] w);
    string n;
    int    f3 = int'(w[14:12]);
    bit    f7 = w[30];
    case (kind(w))
      0: begin
        n = alu_names[f3];
        if (f7) n = (n == "ADD") ? "SUB" : (n == "SRL") ? "SRA" : "BAD";
      end
      1: begin
        n = alu_names[f3];
        if (f7 && n == "SRL") n = "SRA";
      end
      2:       n = (f3 == 2) ? "LW" : "BAD";
      3:       n = (f3 == 2) ? "SW" : "BAD";
      4:       n = br_names[f3];
      default: n = "BAD";
    endcase
    if (n == "SLTU") n = "BAD";
    return n;
  endfunction

  function automatic logic [3:0] op_of(input string m);
    if (m == "LW" || m == "SW") return 4'd0;
    if (m == "BEQ" || m == "BNE" || m == "BLT" || m == "BGE") return 4'd1;
    for (int i = 0; i < 9; i++)
      if (op_names[i] == m) return 4'(i);
    return 4'hF;
  endfunction

  function automatic bit taken(input string m, input logic [3:0] s);
    bit z = s[3];
    bit lt = s[2] ^ s[0];
    if (m == "BEQ") return z;
    if (m == "BNE") return !z;
    if (m == "BLT") return lt;
    if (m == "BGE") return !lt;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 9))
      0, 1: w[6:0] = 7'b0110011;
      2, 3: w[6:0] = 7'b0010011;
      4:    w[6:0] = 7'b0000011;
      5:    w[6:0] = 7'b0100011;
      6, 7: w[6:0] = 7'b1100011;
      default: ;
    endcase
    if ((w[6:0] == 7'b0000011 || w[6:0] == 7'b0100011) && $urandom_range(0, 3) != 0)
      w[14:12] = 3'b010;
    if ($urandom_range(0, 2) != 0) w[30] = 1'b0;
    return w;
  endfunction

  // One clock cycle of stimulus plus the outputs the DUT must show during it.
  task automatic step(input bit r, input bit e, input logic [31:0] w,
                      input logic [3:0] s, input out_t ex, input string tag);
    exp_t item;
    @(posedge clk);
    #1;
    rst = r; en = e; instr = w; status = s;
    item.v = ex;
    item.tag = tag;
    exp_q.push_back(item);
  endtask

  task automatic retire();
    model_cnt = (model_cnt + 1) % (1 << IW);
  endtask

  task automatic applyStimulus(input logic [31:0] w, input int smode);
    string      m = mnemonic(w);
    int         k = kind(w);
    logic [3:0] s;
    step(0, 1, w, 4'($urandom), mk0(), {m, " fetch"});
    step(0, 1'($urandom), $urandom, 4'($urandom), mk0(), {m, " decode"});
    if (m == "BAD") begin
      repeat (3) step(0, 1'($urandom), $urandom, 4'($urandom),
                      mk(0, 0, 0, 0, 4'd0, 0, 0, 0, 1), "halt");
      model_cnt = 0;
      step(1, 0, $urandom, 4'($urandom), mk0(), "halt reset");
      step(0, 0, $urandom, 4'($urandom), mk0(), "after halt reset");
      return;
    end
    s = (smode < 0) ? 4'($urandom) : smode[3:0];
    case (k)
      4: begin
        step(0, 1'($urandom), $urandom, s, mk(1, taken(m, s), 0, 0, 4'd1, 1, 0, 0, 0),
             {m, " exec"});
        retire();
      end
      2, 3: begin
        step(0, 1'($urandom), $urandom, s, mk(0, 0, 1, 0, 4'd0, k == 3, 0, 0, 0),
             {m, " exec"});
        if (k == 3) begin
          step(0, 1'($urandom), $urandom, 4'($urandom), mk(1, 0, 0, 0, 4'd0, 0, 1, 0, 0),
               {m, " mem"});
        end else begin
          step(0, 1'($urandom), $urandom, 4'($urandom), mk0(), {m, " mem"});
          step(0, 1'($urandom), $urandom, 4'($urandom), mk(1, 0, 0, 1, 4'd0, 0, 0, 1, 0),
               {m, " wb"});
        end
        retire();
      end
      default: begin
        step(0, 1'($urandom), $urandom, s, mk(0, 0, k == 1, 0, op_of(m), 0, 0, 0, 0),
             {m, " exec"});
        step(0, 1'($urandom), $urandom, 4'($urandom), mk(1, 0, 0, 0, 4'd0, 0, 0, 1, 0),
             {m, " wb"});
        retire();
      end
    endcase
    repeat ($urandom_range(0, 2))
      step(0, 0, $urandom, 4'($urandom), mk0(), "idle");
  endtask

  // Load interrupted by reset in MEM (phase 0) or in WB (phase 1).
  task automatic abortLoad(input int phase);
    logic [31:0] w = 32'h0080A283;
    step(0, 1, w, 4'($urandom), mk0(), "abort fetch");
    step(0, 1, $urandom, 4'($urandom), mk0(), "abort decode");
    step(0, 1, $urandom, 4'($urandom), mk(0, 0, 1, 0, 4'd0, 0, 0, 0, 0), "abort exec");
    if (phase == 1)
      step(0, 1, $urandom, 4'($urandom), mk0(), "abort mem");
    model_cnt = 0;
    step(1, 1, $urandom, 4'($urandom), mk0(), phase == 0 ? "rst in MEM" : "rst in WB");
    step(1, 1, $urandom, 4'($urandom), mk0(), "rst held");
    step(0, 0, $urandom, 4'($urandom), mk0(), "rst released");
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    out_t act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {pc_we, pcsrc, wb, alusrc, aluop, immgen_ctrl, mrw, regrw, halted, instret};
      checkOutput(e, act);
    end
  end

  task automatic checkOutput(input exp_t e, input out_t act);
    checks++;
    if (act === e.v)
      passes++;
    else
      $display("[TB] FAIL %s: got %h expected %h (pc_we,pcsrc,wb,alusrc,aluop,imm,mrw,regrw,halted,instret)",
               e.tag, act, e.v);
  endtask

  initial begin
    step(1, 0, 32'h0, 4'h0, mk0(), "reset");
    step(1, 0, 32'h0, 4'h0, mk0(), "reset held");
    step(0, 0, 32'h0, 4'h0, mk0(), "idle after reset");

    applyStimulus(32'h002081B3, -1);
    applyStimulus(32'h0080A283, -1);
    applyStimulus(32'h0020A223, -1);
    applyStimulus(32'h00208463, 8);
    applyStimulus(32'h00208463, 0);
    applyStimulus(32'h0020B1B3, -1);
    abortLoad(0);
    abortLoad(1);
    repeat (18) applyStimulus(32'h00208463, -1);
    repeat (150) applyStimulus(rand_instr(), -1);

    step(0, 0, 32'h0, 4'h0, mk0(), "final idle");
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0)
      passes++;
    else
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
